// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the RAM port arbiter.
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin arbitration.
package ram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // Wide enough to hold RD_LAT-1 for RD_LAT in 1..4.
  localparam int LAT_W = 2;

endpackage

// File: rtl/ram_rr_arbiter.sv
// Combinational two-port grant selection.
// With ARB_ROUND_ROBIN_EN defined, simultaneous requests go to the port
// not granted last; otherwise port 0 has fixed priority.
module ram_rr_arbiter
  import ram_ctrl_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_id
);

`ifdef ARB_ROUND_ROBIN_EN
  // Alternate on contention; a lone request always wins.
  always_comb begin
    grant_id = PORT0;
    if (req == 2'b11)
      grant_id = ~last_grant;
    else if (req[1])
      grant_id = PORT1;
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  // Port 0 wins whenever it is requesting.
  always_comb begin
    grant_id = PORT0;
    if (!req[0] && req[1])
      grant_id = PORT1;
  end
`endif

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch (port 0)
// and data access (port 1). One transaction at a time, one-cycle ack.
// Optional macro ARB_ROUND_ROBIN_EN enables round-robin arbitration.
//
// state | meaning
// IDLE  | no transaction; arbitrate and latch winner on any request
// ISSUE | RAM strobe high for one cycle
// WAIT  | read only; RD_LAT cycles until ram_dataOut is valid
// DONE  | winner's ack high, rdata valid
module ram_port_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int BITS    = 32,
  parameter int RAMSIZE = 512,
  parameter int ADDR    = $clog2(RAMSIZE),
  parameter int RD_LAT  = 1
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            p0_req,
  input  logic            p0_we,
  input  logic [ADDR-1:0] p0_addr,
  input  logic [BITS-1:0] p0_wdata,
  output logic            p0_ack,
  output logic [BITS-1:0] p0_rdata,
  input  logic            p1_req,
  input  logic            p1_we,
  input  logic [ADDR-1:0] p1_addr,
  input  logic [BITS-1:0] p1_wdata,
  output logic            p1_ack,
  output logic [BITS-1:0] p1_rdata,
  output logic            ram_read,
  output logic            ram_write,
  output logic [ADDR-1:0] ram_address,
  output logic [BITS-1:0] ram_dataIn,
  input  logic [BITS-1:0] ram_dataOut,
  output logic            busy
);

  state_t           state_q, state_d;
  logic [1:0]       req;
  logic             grant_id;
  logic             last_grant;
  logic             cur_port;
  logic             win_we;
  logic [LAT_W-1:0] lat_cnt;

  assign req    = {p1_req, p0_req};
  assign win_we = (grant_id == PORT1) ? p1_we : p0_we;
  assign busy   = (state_q != IDLE);

  ram_rr_arbiter u_arb (
    .req        (req),
    .last_grant (last_grant),
    .grant_id   (grant_id)
  );

`ifdef ARB_ROUND_ROBIN_EN
  // Remember who was granted last so contention alternates.
  always_ff @(posedge clk or posedge clr) begin
    if (clr)
      last_grant <= PORT0;
    else if (state_q == IDLE && req != 2'b00)
      last_grant <= grant_id;
  end
`else
  assign last_grant = PORT0;
`endif

  // State register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Next-state: writes skip WAIT; reads leave WAIT at terminal count.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req != 2'b00) state_d = ISSUE;
      ISSUE:   state_d = ram_write ? DONE : WAIT;
      WAIT:    if (lat_cnt == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: latch winner, registered strobes, latency counter, acks, rdata.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ram_read    <= 1'b0;
      ram_write   <= 1'b0;
      ram_address <= '0;
      ram_dataIn  <= '0;
      p0_ack      <= 1'b0;
      p1_ack      <= 1'b0;
      p0_rdata    <= '0;
      p1_rdata    <= '0;
      cur_port    <= PORT0;
      lat_cnt     <= '0;
    end else begin
      ram_read  <= 1'b0;
      ram_write <= 1'b0;
      p0_ack    <= 1'b0;
      p1_ack    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req != 2'b00) begin
            cur_port    <= grant_id;
            ram_address <= (grant_id == PORT1) ? p1_addr : p0_addr;
            if (win_we)
              ram_dataIn <= (grant_id == PORT1) ? p1_wdata : p0_wdata;
            ram_write   <= win_we;
            ram_read    <= ~win_we;
          end
        end
        ISSUE: begin
          lat_cnt <= LAT_W'(RD_LAT - 1);
          if (ram_write) begin
            p0_ack <= (cur_port == PORT0);
            p1_ack <= (cur_port == PORT1);
          end
        end
        WAIT: begin
          if (lat_cnt == '0) begin
            p0_ack <= (cur_port == PORT0);
            p1_ack <= (cur_port == PORT1);
            if (cur_port == PORT1)
              p1_rdata <= ram_dataOut;
            else
              p0_rdata <= ram_dataOut;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter with a scoreboard of expected acks.
// Honours ARB_ROUND_ROBIN_EN for the fairness expectations.
module tb_ram_port_arbiter;

  localparam int BITS   = 32;
  localparam int ADDR   = 9;
  localparam int RD_LAT = 3;

  logic            clk = 1'b0;
  logic            clr = 1'b1;
  logic            p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
  logic [ADDR-1:0] p0_addr = '0, p1_addr = '0;
  logic [BITS-1:0] p0_wdata = '0, p1_wdata = '0;
  logic            p0_ack, p1_ack, ram_read, ram_write, busy;
  logic [BITS-1:0] p0_rdata, p1_rdata, ram_dataIn, ram_dataOut;
  logic [ADDR-1:0] ram_address;

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [31:0] model [0:511];
  logic [31:0] mem   [0:511];
  logic [31:0] pipe  [RD_LAT];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          wr_w  = 0;
  int          rd_w  = 0;

  ram_port_arbiter #(.BITS(BITS), .RAMSIZE(512), .ADDR(ADDR), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .clr(clr),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .ram_read(ram_read), .ram_write(ram_write), .ram_address(ram_address),
    .ram_dataIn(ram_dataIn), .ram_dataOut(ram_dataOut), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: data valid RD_LAT edges after the sampling edge.
  always @(posedge clk) begin
    if (ram_write) mem[ram_address] <= ram_dataIn;
    pipe[0] <= mem[ram_address];
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign ram_dataOut = pipe[RD_LAT-1];

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard and strobe-width monitor.
  always @(negedge clk) begin
    if (!clr) begin
      if (p0_ack && p1_ack) chk_val("dual_ack", {p1_ack, p0_ack}, 2'b01);
      else if (p0_ack || p1_ack) begin
        if (sb.size() == 0) chk_val("sb_extra_ack", {p1_ack, p0_ack}, 2'b00);
        else begin
          e = sb.pop_front();
          chk_val("sb_port", p1_ack, e.port);
          if (!e.we) chk_val("sb_rdata", p1_ack ? p1_rdata : p0_rdata, e.data);
        end
      end
      if (ram_write) wr_w++;
      else if (wr_w != 0) begin chk_val("wr_width", wr_w, 1); wr_w = 0; end
      if (ram_read) rd_w++;
      else if (rd_w != 0) begin chk_val("rd_width", rd_w, 1); rd_w = 0; end
    end
  end

  task automatic drive(input logic port, input logic we, input logic [ADDR-1:0] addr,
                       input logic [31:0] data);
    if (port) begin p1_we = we; p1_addr = addr; p1_wdata = data; p1_req = 1'b1; end
    else      begin p0_we = we; p0_addr = addr; p0_wdata = data; p0_req = 1'b1; end
  endtask

  task automatic drop(input logic port);
    if (port) p1_req = 1'b0; else p0_req = 1'b0;
  endtask

  task automatic push_exp(input logic port, input logic we, input logic [ADDR-1:0] addr,
                          input logic [31:0] data);
    exp_t x;
    x.port = port;
    x.we   = we;
    x.data = we ? 32'h0 : model[addr];
    if (we) model[addr] = data;
    sb.push_back(x);
  endtask

  // Counts negedges from the request's IDLE cycle until the port's ack (0 = timeout).
  task automatic wait_ack(input logic port, output int n, output int at);
    n  = 0;
    at = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (port ? p1_ack : p0_ack) begin n = i; at = cyc; break; end
    end
  endtask

  task automatic run_txn(input logic port, input logic we, input logic [ADDR-1:0] addr,
                         input logic [31:0] data);
    int n, at;
    push_exp(port, we, addr, data);
    drive(port, we, addr, data);
    wait_ack(port, n, at);
    chk_val(we ? "lat_wr" : "lat_rd", n, we ? 3 : 3 + RD_LAT);
    @(posedge clk); #1;
    drop(port);
  endtask

  initial begin
    int n0, n1, a0, a1, acks;
    logic exp_first;

    // Reset state
    #12;
    chk_val("rst_busy", busy, 0);
    chk_val("rst_strobes", {ram_read, ram_write}, 0);
    chk_val("rst_acks", {p0_ack, p1_ack}, 0);
    chk_val("rst_rdata", {p0_rdata, p1_rdata}, 0);
    chk_val("rst_addr", ram_address, 0);
    @(posedge clk); #1;
    clr = 1'b0;

    // Abort a write mid-ISSUE: strobe drops asynchronously, no ack
    drive(0, 1, 9'h007, 32'h1111_2222);
    @(negedge clk);
    @(negedge clk);
    chk_val("abort_pre_wr", ram_write, 1);
    chk_val("abort_pre_busy", busy, 1);
    #2 clr = 1'b1;
    #1;
    chk_val("abort_wr_async", ram_write, 0);
    chk_val("abort_busy", busy, 0);
    drop(0);
    repeat (3) begin
      @(negedge clk);
      chk_val("abort_no_ack", {p0_ack, p1_ack}, 0);
    end
    chk_val("abort_rdata", {p0_rdata, p1_rdata}, 0);
    @(posedge clk); #1;
    clr = 1'b0;
    @(posedge clk); #1;

    // Write then read on port 1
    run_txn(1, 1, 9'h003, 32'h0000_0005);
    run_txn(1, 0, 9'h003, 32'h0);

    // Top address with configured read latency
    run_txn(0, 1, 9'h1FF, 32'hDEAD_BEEF);
    run_txn(0, 0, 9'h1FF, 32'h0);
    chk_val("p1_rdata_hold", p1_rdata, 32'h5);

    // Last grant is port 1 here, so both arbiters serve port 0 first
    run_txn(1, 1, 9'h010, 32'h0000_1234);
    push_exp(0, 0, 9'h010, 32'h0);
    push_exp(1, 1, 9'h020, 32'h0000_00AA);
    drive(0, 0, 9'h010, 32'h0);
    drive(1, 1, 9'h020, 32'h0000_00AA);
    fork
      begin wait_ack(0, n0, a0); @(posedge clk); #1; drop(0); end
      begin wait_ack(1, n1, a1); @(posedge clk); #1; drop(1); end
    join
    chk_val("cont_p0_lat", n0, 3 + RD_LAT);
    chk_val("cont_p1_gap", a1 - a0, 3);
    chk_val("p0_rdata_after_wr", p0_rdata, 32'h1234);
    run_txn(1, 0, 9'h020, 32'h0);

    // Fairness: both ports hold requests for six grants
`ifdef ARB_ROUND_ROBIN_EN
    exp_first = 1'b0;
    for (int i = 0; i < 6; i++) push_exp(exp_first ^ i[0], 1, exp_first ^ i[0] ? 9'h031 : 9'h030,
                                         exp_first ^ i[0] ? 32'hB : 32'hA);
`else
    exp_first = 1'b0;
    for (int i = 0; i < 6; i++) push_exp(exp_first, 1, 9'h030, 32'hA);
`endif
    drive(0, 1, 9'h030, 32'hA);
    drive(1, 1, 9'h031, 32'hB);
    acks = 0;
    for (int i = 0; i < 300 && acks < 6; i++) begin
      @(negedge clk);
      if (p0_ack || p1_ack) acks++;
    end
    chk_val("fair_acks", acks, 6);
    @(posedge clk); #1;
    drop(0);
    drop(1);
    @(posedge clk); #1;

    // Address change during WAIT is ignored
    push_exp(0, 0, 9'h003, 32'h0);
    drive(0, 0, 9'h003, 32'h0);
    repeat (3) @(negedge clk);
    chk_val("stab_busy", busy, 1);
    p0_addr = 9'h1FF;
    wait_ack(0, n0, a0);
    chk_val("stab_lat", n0 + 3, 3 + RD_LAT);
    chk_val("stab_rdata", p0_rdata, 32'h5);
    @(posedge clk); #1;
    drop(0);
    repeat (4) @(negedge clk);
    chk_val("end_idle", busy, 0);
    chk_val("sb_left", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Two-requester controller sharing the single-port synchronous RAM (BITS x RAMSIZE) between instruction fetch (port 0) and data access (port 1).
- Accepts one request at a time, sequences the RAM read/write/address/dataIn strobes, waits out the read latency, and returns data with a one-cycle ack pulse.
- Sits between the CPU bus logic and the RAM instance.

Parameters:
- BITS, 32, data word width
- RAMSIZE, 512, number of RAM words
- ADDR, $clog2(RAMSIZE), address width
- RD_LAT, 1, clock edges from the edge sampling ram_read=1 until ram_dataOut is valid (range 1..4)

Ports:
- clk  in  1  system clock, rising edge
- clr  in  1  asynchronous active-high reset
- p0_req  in  1  port 0 request; held with p0_we/p0_addr/p0_wdata stable until p0_ack
- p0_we  in  1  1 = write, 0 = read
- p0_addr  in  ADDR  word address
- p0_wdata  in  BITS  write data
- p0_ack  out  1  one-cycle completion pulse
- p0_rdata  out  BITS  read data; valid when p0_ack=1 for a read
- p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_rdata: identical set for port 1
- ram_read  out  1  RAM read strobe
- ram_write  out  1  RAM write strobe
- ram_address  out  ADDR  RAM address
- ram_dataIn  out  BITS  RAM write data
- ram_dataOut  in  BITS  RAM read data
- busy  out  1  high in any state other than IDLE

Behaviour:
- One clock (clk); reset clr is asynchronous, active-high.
- Reset values:
  - state = IDLE; all outputs 0, including both rdata registers.
  - Round-robin pointer = port 0.
- FSM states are IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - At the edge, if any req is high, choose the winner and latch its we/addr/wdata plus its port ID; go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - ram_address = latched addr.
  - Write: ram_write=1, ram_dataIn = latched wdata; next state is DONE.
  - Read: ram_read=1; next state is WAIT.
  - Strobes are registered outputs and are high only in ISSUE.
- WAIT (reads only):
  - Stays for RD_LAT cycles, counted by a down-counter.
  - In the last WAIT cycle, ram_dataOut is registered into the winner's rdata; go to DONE.
- DONE (1 cycle):
  - Winner's ack=1; its rdata is valid.
  - Next state is IDLE.
- Latency, with req sampled in IDLE cycle N:
  - Write: ack in cycle N+2.
  - Read: ack in cycle N+2+RD_LAT.
  - Throughput: one access per 3 (write) or 3+RD_LAT (read) cycles.
- Handshake:
  - The requester must drop req at the edge that ends its ack cycle.
  - A req still high in the following IDLE cycle is treated as a new transaction.
  - A req asserted mid-transaction waits; it is never lost.
  - Inputs are not re-sampled after IDLE, so changes during ISSUE/WAIT are ignored.
- Simultaneous requests in IDLE: arbitration per Optional Feature; the loser stays pending and is served next.
- rdata holds its last read value until the next read completes on the same port. Writes do not alter rdata.
- The non-winning port's ack is 0 throughout.
- clr mid-transaction:
  - Ram strobes drop immediately (async) and the transaction is aborted; no ack is issued.
  - A partially committed write is permitted only if clr lands after the ISSUE edge.
- Address is passed straight through with no wrap or bounds check; addresses >= RAMSIZE are the RAM's concern.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN
- Defined:
  - Round-robin arbitration. A last-grant pointer updates on every grant.
  - On simultaneous requests, the port not granted last wins; a single request always wins.
- Undefined:
  - Fixed priority; port 0 always wins simultaneous requests.
  - The pointer register is not built.

Decomposition:
- Package ram_ctrl_pkg holds:
  - state enum (IDLE, ISSUE, WAIT, DONE), 2-bit encoding
  - port ID constants PORT0=0, PORT1=1
  - RD_LAT counter width constant
- Sub-module ram_rr_arbiter: inputs req[1:0], last_grant; outputs grant_id.
  - Purely combinational.
  - Contains both the fixed-priority and round-robin variants under the macro.
- The FSM and datapath registers stay in ram_port_arbiter.

Test Plan:
1. Reset: assert clr for 3 cycles mid-ISSUE of a write -> ram_write falls without waiting for an edge, no ack, busy=0, rdata=0.
2. Write then read: p1 writes 0x5 to addr 0x3 (ram_write=1 for exactly 1 cycle, p1_ack at N+2), then p1 reads 0x3 -> p1_ack at N+3 (RD_LAT=1), p1_rdata=0x5.
3. Contention: p0 reads 0x10 and p1 writes 0xAA to 0x20 in the same IDLE cycle -> p0 served first, p1 served immediately after; both acks fire once.
4. Fairness (ARB_ROUND_ROBIN_EN): both ports hold req continuously for 6 transactions -> grants alternate p0,p1,p0,p1,p0,p1. Without the macro, p0 takes all 6.
5. Latency parameter: RD_LAT=3, read from addr 0x1FF holding 0xDEADBEEF -> ack at N+5, rdata=0xDEADBEEF; ram_read high only in the ISSUE cycle.
6. Stability: change p0_addr during WAIT -> returned data corresponds to the address latched in IDLE.
